// File: rtl/latency_stat_collector_pkg.sv
// Shared types and constants for the latency statistics collector.
// Snapshot layout and FSM state encodings.
package latency_stat_collector_pkg;

    typedef struct packed {
        logic [7:0]  seq;
        logic [15:0] cnt;
        logic [7:0]  max;
        logic [7:0]  min;
    } lat_snap_t;

    localparam logic [1:0] LATSTAT_IDLE  = 2'd0;
    localparam logic [1:0] LATSTAT_PRIME = 2'd1;
    localparam logic [1:0] LATSTAT_COUNT = 2'd2;

    // Min latency reset value; reported while the window packet count is zero.
    localparam logic [7:0] LAT_MIN_RST = 8'd255;

endpackage

// File: rtl/lat_snap_fifo.sv
// First-word fall-through FIFO of latency snapshots.
// A push while full is accepted only when a pop happens in the same cycle.
module lat_snap_fifo
    import latency_stat_collector_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  lat_snap_t wdata,
    output lat_snap_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    lat_snap_t   mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Extra MSB on each pointer distinguishes full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/latency_stat_collector.sv
// Windowed capture of latency_mon statistics into a snapshot stream.
// Pulses mon_upd at every window end and queues the final window values.
module latency_stat_collector
    import latency_stat_collector_pkg::*;
#(
    parameter int unsigned WIN_W      = 32,
    parameter int unsigned SNAP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_en,
    input  logic [WIN_W-1:0] cfg_window,
    output logic             mon_upd,
    input  logic [7:0]       latency_min,
    input  logic [7:0]       latency_max,
    input  logic [15:0]      latency_pkt_cnt,
    output logic             snap_valid,
    input  logic             snap_ready,
    output logic [7:0]       snap_min,
    output logic [7:0]       snap_max,
    output logic [15:0]      snap_cnt,
    output logic [7:0]       snap_seq,
    output logic [15:0]      drop_cnt
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_cnt_nxt;
    logic [WIN_W-1:0] win_lim;
    logic             mon_upd_nxt;
    logic [7:0]       seq;
    logic             capture;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    lat_snap_t        snap_in;
    lat_snap_t        head;

    assign win_lim = (cfg_window == '0) ? '0 : cfg_window - 1'b1;

    always_comb begin
        state_nxt   = state;
        win_cnt_nxt = win_cnt;
        mon_upd_nxt = 1'b0;
        case (state)
            LATSTAT_IDLE: begin
                win_cnt_nxt = '0;
                if (cfg_en) begin
                    state_nxt   = LATSTAT_PRIME;
                    mon_upd_nxt = 1'b1;
                end
            end
            LATSTAT_PRIME: begin
                if (!cfg_en) begin
                    state_nxt   = LATSTAT_IDLE;
                    win_cnt_nxt = '0;
                end else begin
                    // The flush cycle is cycle 0 of the first window.
                    state_nxt = LATSTAT_COUNT;
                    if (win_lim == '0) begin
                        mon_upd_nxt = 1'b1;
                        win_cnt_nxt = '0;
                    end else begin
                        win_cnt_nxt = WIN_W'(1);
                    end
                end
            end
            LATSTAT_COUNT: begin
                if (!cfg_en) begin
                    state_nxt   = LATSTAT_IDLE;
                    win_cnt_nxt = '0;
                end else if (win_cnt >= win_lim) begin
                    mon_upd_nxt = 1'b1;
                    win_cnt_nxt = '0;
                end else begin
                    win_cnt_nxt = win_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt   = LATSTAT_IDLE;
                win_cnt_nxt = '0;
            end
        endcase
    end

    // A pulse seen while in COUNT closes a real window; the PRIME pulse only flushes.
    assign capture = mon_upd && (state == LATSTAT_COUNT);
    assign pop     = !fifo_empty && snap_ready;
    assign drop    = capture && fifo_full && !pop;
    assign snap_in = {seq, latency_pkt_cnt, latency_max, latency_min};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LATSTAT_IDLE;
            win_cnt  <= '0;
            mon_upd  <= 1'b0;
            seq      <= 8'd0;
            drop_cnt <= 16'd0;
        end else begin
            state   <= state_nxt;
            win_cnt <= win_cnt_nxt;
            mon_upd <= mon_upd_nxt;
            if (capture) seq <= seq + 8'd1;
            if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    lat_snap_fifo #(
        .DEPTH (SNAP_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (capture),
        .pop   (pop),
        .wdata (snap_in),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign snap_valid = !fifo_empty;
    assign snap_min   = head.min;
    assign snap_max   = head.max;
    assign snap_cnt   = head.cnt;
    assign snap_seq   = head.seq;

endmodule

// File: tb/tb_latency_stat_collector.sv
// Self-checking bench for latency_stat_collector with a window/queue reference model.
// Directed scenarios followed by a randomized run.
module tb_latency_stat_collector;
    import latency_stat_collector_pkg::*;

    localparam int unsigned WIN_W = 32;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_en = 1'b0;
    logic [31:0] cfg_window = 32'd10;
    logic        mon_upd;
    logic [7:0]  latency_min = 8'd255;
    logic [7:0]  latency_max = 8'd0;
    logic [15:0] latency_pkt_cnt = 16'd0;
    logic        snap_valid;
    logic        snap_ready = 1'b0;
    logic [7:0]  snap_min;
    logic [7:0]  snap_max;
    logic [15:0] snap_cnt;
    logic [7:0]  snap_seq;
    logic [15:0] drop_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model: pulses fall every W cycles counted from the flush pulse.
    lat_snap_t mq[$];
    int        m_seq;
    int        m_drop;
    bit        run;
    int        k;
    bit        exp_upd;
    bit        exp_cap;

    latency_stat_collector #(
        .WIN_W      (WIN_W),
        .SNAP_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_en          (cfg_en),
        .cfg_window      (cfg_window),
        .mon_upd         (mon_upd),
        .latency_min     (latency_min),
        .latency_max     (latency_max),
        .latency_pkt_cnt (latency_pkt_cnt),
        .snap_valid      (snap_valid),
        .snap_ready      (snap_ready),
        .snap_min        (snap_min),
        .snap_max        (snap_max),
        .snap_cnt        (snap_cnt),
        .snap_seq        (snap_seq),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic model_reset();
        mq.delete();
        m_seq = 0; m_drop = 0; run = 0; k = 0; exp_upd = 0; exp_cap = 0;
    endtask

    task automatic model_update();
        int w;
        if (mq.size() > 0 && snap_ready) void'(mq.pop_front());
        if (exp_cap) begin
            if (mq.size() < DEPTH)
                mq.push_back('{seq: 8'(m_seq), cnt: latency_pkt_cnt, max: latency_max,
                               min: latency_min});
            else if (m_drop < 65535)
                m_drop++;
            m_seq = (m_seq + 1) % 256;
        end
        w = (cfg_window == 32'd0) ? 1 : int'(cfg_window);
        if (!cfg_en) begin
            run = 0; exp_upd = 0; exp_cap = 0;
        end else if (!run) begin
            run = 1; k = 0; exp_upd = 1; exp_cap = 0;
        end else begin
            k++;
            exp_upd = (k % w == 0);
            exp_cap = exp_upd;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic rand_stats();
        latency_min     = 8'($urandom);
        latency_max     = 8'($urandom);
        latency_pkt_cnt = 16'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; cfg_en = 1'b0; snap_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        tests++;
        if (mon_upd !== 1'b0 || snap_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: mon_upd=%b snap_valid=%b, required 0 0", mon_upd, snap_valid);
        end
        tests++;
        if (drop_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_drop: got %0d, required 0", drop_cnt);
        end
        tests++;
        if ({snap_min, snap_max, snap_cnt, snap_seq} !== 40'd0) begin
            fails++;
            $display("FAIL reset_data: got %h, required 0",
                     {snap_min, snap_max, snap_cnt, snap_seq});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_window();
        int got[$];
        int req[4] = '{1, 11, 21, 31};
        do_reset();
        cfg_window = 32'd10; snap_ready = 1'b1; cfg_en = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            tick();
            tests++;
            if (mon_upd !== exp_upd) begin
                fails++;
                $display("FAIL window_upd cycle %0d: got %b, required %b", i, mon_upd, exp_upd);
            end
            if (mon_upd === 1'b1) got.push_back(i);
        end
        tests++;
        if (got.size() != 4) begin
            fails++;
            $display("FAIL window_count: got %0d pulses, required 4", got.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                tests++;
                if (got[j] != req[j]) begin
                    fails++;
                    $display("FAIL window_time %0d: got t0+%0d, required t0+%0d", j, got[j], req[j]);
                end
            end
        end
        cfg_en = 1'b0;
    endtask

    task automatic test_capture();
        int n = 0;
        do_reset();
        cfg_window = 32'd10; snap_ready = 1'b0;
        latency_min = 8'd3; latency_max = 8'd40; latency_pkt_cnt = 16'd7;
        cfg_en = 1'b1;
        while (snap_valid !== 1'b1 && n < 40) begin tick(); n++; end
        tests++;
        if (snap_valid !== 1'b1) begin
            fails++;
            $display("FAIL capture_wait: snap_valid timeout, required 1");
        end else begin
            tests++;
            if (n != 12) begin
                fails++;
                $display("FAIL capture_latency: valid at t0+%0d, required t0+12", n);
            end
            tests++;
            if ({snap_min, snap_max, snap_cnt, snap_seq} !== {8'd3, 8'd40, 16'd7, 8'd0}) begin
                fails++;
                $display("FAIL capture_data: got %0d/%0d/%0d/%0d, required 3/40/7/0",
                         snap_min, snap_max, snap_cnt, snap_seq);
            end
        end
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
        tests++;
        if (snap_valid !== 1'b0) begin
            fails++;
            $display("FAIL capture_pop: snap_valid=%b, required 0", snap_valid);
        end
        n = 0;
        while (snap_valid !== 1'b1 && n < 20) begin tick(); n++; end
        tests++;
        if (snap_valid !== 1'b1 || snap_seq !== 8'd1) begin
            fails++;
            $display("FAIL capture_seq1: valid=%b seq=%0d, required 1 1", snap_valid, snap_seq);
        end
        cfg_en = 1'b0;
    endtask

    task automatic test_overflow();
        int n = 0;
        do_reset();
        cfg_window = 32'd10; snap_ready = 1'b0; cfg_en = 1'b1;
        for (int i = 1; i <= 65; i++) begin rand_stats(); tick(); end
        tests++;
        if (drop_cnt !== 16'd2 || snap_valid !== 1'b1) begin
            fails++;
            $display("FAIL overflow_drop: drop=%0d valid=%b, required 2 1", drop_cnt, snap_valid);
        end
        snap_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tests++;
            if (snap_seq !== 8'(j) || mq.size() == 0 ||
                {snap_seq, snap_cnt, snap_max, snap_min} !== mq[0]) begin
                fails++;
                $display("FAIL overflow_drain %0d: got seq %0d, required seq %0d", j, snap_seq, j);
            end
            rand_stats();
            tick();
        end
        snap_ready = 1'b0;
        tests++;
        if (snap_valid !== 1'b0) begin
            fails++;
            $display("FAIL overflow_empty: snap_valid=%b, required 0", snap_valid);
        end
        while (snap_valid !== 1'b1 && n < 20) begin tick(); n++; end
        tests++;
        if (snap_valid !== 1'b1 || snap_seq !== 8'd6) begin
            fails++;
            $display("FAIL overflow_seq6: valid=%b seq=%0d, required 1 6", snap_valid, snap_seq);
        end
        cfg_en = 1'b0;
    endtask

    task automatic test_full_pop();
        int n = 0;
        do_reset();
        cfg_window = 32'd4; snap_ready = 1'b0; cfg_en = 1'b1;
        while (mq.size() < DEPTH && n < 40) begin rand_stats(); tick(); n++; end
        n = 0;
        while (!exp_cap && n < 10) begin rand_stats(); tick(); n++; end
        tests++;
        if (mon_upd !== 1'b1 || dut.snap_valid !== 1'b1) begin
            fails++;
            $display("FAIL fullpop_setup: mon_upd=%b valid=%b, required 1 1", mon_upd, snap_valid);
        end
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
        tests++;
        if (drop_cnt !== 16'd0 || snap_seq !== 8'd1) begin
            fails++;
            $display("FAIL fullpop_both: drop=%0d seq=%0d, required 0 1", drop_cnt, snap_seq);
        end
        snap_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tests++;
            if (snap_valid !== 1'b1 || snap_seq !== 8'(j)) begin
                fails++;
                $display("FAIL fullpop_order %0d: valid=%b seq=%0d, required 1 %0d",
                         j, snap_valid, snap_seq, j);
            end
            tick();
        end
        snap_ready = 1'b0; cfg_en = 1'b0;
    endtask

    task automatic test_disable();
        int got[$];
        int req[3] = '{1, 11, 21};
        do_reset();
        cfg_window = 32'd10; snap_ready = 1'b1; cfg_en = 1'b1;
        repeat (6) tick();
        cfg_en = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            tests++;
            if (mon_upd !== 1'b0) begin
                fails++;
                $display("FAIL disable_quiet cycle %0d: got %b, required 0", i, mon_upd);
            end
        end
        cfg_en = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (mon_upd === 1'b1) got.push_back(i);
        end
        tests++;
        if (got.size() != 3) begin
            fails++;
            $display("FAIL reenable_count: got %0d pulses, required 3", got.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                tests++;
                if (got[j] != req[j]) begin
                    fails++;
                    $display("FAIL reenable_time %0d: got +%0d, required +%0d", j, got[j], req[j]);
                end
            end
        end
        cfg_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        cfg_window = 32'd3; snap_ready = 1'b0; cfg_en = 1'b1;
        while (m_drop < 2 && n < 60) begin rand_stats(); tick(); n++; end
        tick();
        tests++;
        if (drop_cnt !== 16'd2) begin
            fails++;
            $display("FAIL resetmid_pre: drop=%0d, required 2", drop_cnt);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if (snap_valid !== 1'b0 || mon_upd !== 1'b0 || drop_cnt !== 16'd0) begin
            fails++;
            $display("FAIL resetmid_async: valid=%b upd=%b drop=%0d, required 0 0 0",
                     snap_valid, mon_upd, drop_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (snap_valid !== 1'b1 && n < 20) begin tick(); n++; end
        tests++;
        if (snap_valid !== 1'b1 || snap_seq !== 8'd0) begin
            fails++;
            $display("FAIL resetmid_seq: valid=%b seq=%0d, required 1 0", snap_valid, snap_seq);
        end
        cfg_en = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        cfg_window = 32'd3;
        for (int i = 0; i < 700; i++) begin
            tests++;
            if (mon_upd !== exp_upd) begin
                fails++;
                $display("FAIL rand_upd %0d: got %b, required %b", i, mon_upd, exp_upd);
            end
            tests++;
            if (snap_valid !== (mq.size() != 0)) begin
                fails++;
                $display("FAIL rand_valid %0d: got %b, required %b", i, snap_valid, mq.size() != 0);
            end
            tests++;
            if (drop_cnt !== 16'(m_drop)) begin
                fails++;
                $display("FAIL rand_drop %0d: got %0d, required %0d", i, drop_cnt, m_drop);
            end
            if (mq.size() != 0) begin
                tests++;
                if ({snap_seq, snap_cnt, snap_max, snap_min} !== mq[0]) begin
                    fails++;
                    $display("FAIL rand_head %0d: got %h, required %h", i,
                             {snap_seq, snap_cnt, snap_max, snap_min}, mq[0]);
                end
            end
            if ($urandom_range(0, 29) == 0) cfg_en = ~cfg_en;
            if (!cfg_en && $urandom_range(0, 3) == 0) cfg_window = $urandom_range(0, 6);
            snap_ready = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                              : ($urandom_range(0, 3) == 0);
            rand_stats();
            tick();
        end
        cfg_en = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_window();
        test_capture();
        test_overflow();
        test_full_pop();
        test_disable();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
